// File: rtl/vp_pkg.sv
// ---------------------------------------------------------------------------
// vp_pkg
// Shared video-path definitions: pixel and packed-word widths, FIFO entry
// width ({sof, word}), the 2-bit packing phase encoding and the helper that
// builds the zero-padded word written when a frame ends mid-word.
// ---------------------------------------------------------------------------
package vp_pkg;

   localparam int PIXEL_W = 24;
   localparam int WORD_W  = 32;
   localparam int FIFO_W  = WORD_W + 1;

   // Packing phase: number of pixels already folded into the current word group
   typedef enum logic [1:0] {
      PH_0 = 2'd0,
      PH_1 = 2'd1,
      PH_2 = 2'd2,
      PH_3 = 2'd3
   } phase_e;

   // Zero-padded partial word emitted at frame end for the given phase
   function automatic logic [WORD_W-1:0] flush_word(input phase_e ph,
                                                    input logic [PIXEL_W-1:0] res);
      logic [WORD_W-1:0] w;
      case (ph)
         PH_1:    w = {8'h00, res[23:0]};
         PH_2:    w = {16'h0000, res[15:0]};
         PH_3:    w = {24'h00_0000, res[7:0]};
         default: w = {WORD_W{1'b0}};
      endcase
      return w;
   endfunction

endpackage

// File: rtl/vp_sync_fifo.sv
// ---------------------------------------------------------------------------
// vp_sync_fifo
// Single-clock show-ahead FIFO. The head entry is presented combinationally
// and reads as zero while empty. A push while full is accepted only when a
// pop happens in the same cycle.
//   clk, rst       : clock, synchronous active-high reset
//   push/push_data : write request and data
//   pop            : remove head entry (ignored when empty)
//   head_data      : current head entry
//   full, empty    : occupancy flags
// ---------------------------------------------------------------------------
module vp_sync_fifo #(
   parameter int WIDTH = 33,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign full      = (count_q == (AW+1)'(DEPTH));
   assign empty     = (count_q == {(AW+1){1'b0}});
   assign head_data = empty ? {WIDTH{1'b0}} : mem_q[rd_ptr_q];

   // Next-state for pointers and occupancy
   always_comb begin
      pop_ok_s  = pop & ~empty;
      push_ok_s = push & (~full | pop_ok_s);
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      if (push_ok_s) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + (AW+1)'(push_ok_s) - (AW+1)'(pop_ok_s);
   end

   // Pointer and occupancy registers
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         count_q  <= {(AW+1){1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are don't-care until written, head is masked when empty
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

endmodule

// File: rtl/vp_word_packer.sv
// ---------------------------------------------------------------------------
// vp_word_packer
// Packs a gapped 24-bit pixel stream densely (little-endian, 4 pixels -> 3
// words) into 32-bit words, zero-pads and flushes a partial word at frame
// end, and buffers words in a show-ahead FIFO behind a valid/ready port.
//   clk, rst            : pixel clock, synchronous active-high reset
//   EN                  : packing enable, sampled at frame start
//   pre_vs/pre_de       : frame valid / pixel valid from the crop stage
//   pre_data            : pixel {R,G,B}
//   m_valid/m_ready     : head word handshake
//   m_data, m_sof       : head word and first-word-of-frame marker
//   overflow            : sticky, a word was dropped on a full FIFO
//   frame_done          : one-cycle pulse after an enabled frame is flushed
// ---------------------------------------------------------------------------
module vp_word_packer
   import vp_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int FIFO_AW    = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                EN,
   input  logic                pre_vs,
   input  logic                pre_de,
   input  logic [PIXEL_W-1:0]  pre_data,
   output logic                m_valid,
   input  logic                m_ready,
   output logic [WORD_W-1:0]   m_data,
   output logic                m_sof,
   output logic                overflow,
   output logic                frame_done
);

   logic               vs_d_q, vs_d_d;
   logic               vs_arm_q, vs_arm_d;
   logic               frame_en_q, frame_en_d;
   logic               sof_pend_q, sof_pend_d;
   logic               overflow_q, overflow_d;
   logic               frame_done_q, frame_done_d;
   phase_e             phase_q, phase_d;
   logic [PIXEL_W-1:0] res_q, res_d;

   logic               vs_rise_s, vs_fall_s, accept_s, flush_s;
   logic               push_s, pop_s, push_ok_s;
   logic [WORD_W-1:0]  push_word_s;
   logic [FIFO_W-1:0]  head_entry_s;
   logic               fifo_full_s, fifo_empty_s;

   assign m_valid    = ~fifo_empty_s;
   assign m_data     = head_entry_s[WORD_W-1:0];
   assign m_sof      = head_entry_s[WORD_W];
   assign overflow   = overflow_q;
   assign frame_done = frame_done_q;

   // Packing FSM next-state, FIFO push request and status flag updates
   always_comb begin
      // vs_arm blocks a false rising edge when reset releases with pre_vs already high
      vs_rise_s    = pre_vs & ~vs_d_q & vs_arm_q;
      vs_fall_s    = ~pre_vs & vs_d_q;
      accept_s     = frame_en_q & pre_vs & pre_de;
      flush_s      = vs_fall_s & frame_en_q;
      pop_s        = ~fifo_empty_s & m_ready;

      vs_d_d       = pre_vs;
      vs_arm_d     = vs_arm_q | ~pre_vs;
      frame_en_d   = frame_en_q;
      sof_pend_d   = sof_pend_q;
      overflow_d   = overflow_q;
      frame_done_d = flush_s;
      phase_d      = phase_q;
      res_d        = res_q;
      push_s       = 1'b0;
      push_word_s  = {WORD_W{1'b0}};

      if (accept_s) begin
         case (phase_q)
            PH_0: begin
               res_d   = pre_data;
               phase_d = PH_1;
            end
            PH_1: begin
               push_s      = 1'b1;
               push_word_s = {pre_data[7:0], res_q[23:0]};
               res_d[15:0] = pre_data[23:8];
               phase_d     = PH_2;
            end
            PH_2: begin
               push_s      = 1'b1;
               push_word_s = {pre_data[15:0], res_q[15:0]};
               res_d[7:0]  = pre_data[23:16];
               phase_d     = PH_3;
            end
            PH_3: begin
               push_s      = 1'b1;
               push_word_s = {pre_data[23:0], res_q[7:0]};
               phase_d     = PH_0;
            end
            default: begin
               phase_d = PH_0;
            end
         endcase
      end else if (flush_s) begin
         push_s      = (phase_q != PH_0);
         push_word_s = flush_word(phase_q, res_q);
         phase_d     = PH_0;
      end else begin
         phase_d = phase_q;
      end

      // Same acceptance rule as the FIFO: a full FIFO still takes a word if it pops now
      push_ok_s = push_s & (~fifo_full_s | pop_s);

      if (push_ok_s) begin
         sof_pend_d = 1'b0;
      end else begin
         sof_pend_d = sof_pend_q;
      end

      if (push_s & ~push_ok_s) begin
         overflow_d = 1'b1;
      end else begin
         overflow_d = overflow_q;
      end

      // Frame start overrides: a new enabled frame restarts packing and flags
      if (vs_rise_s) begin
         frame_en_d = EN;
         if (EN) begin
            overflow_d = 1'b0;
            sof_pend_d = 1'b1;
            phase_d    = PH_0;
         end else begin
            overflow_d = overflow_d;
         end
      end else begin
         frame_en_d = frame_en_q;
      end
   end

   // Packer state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         vs_d_q       <= 1'b0;
         vs_arm_q     <= 1'b0;
         frame_en_q   <= 1'b0;
         sof_pend_q   <= 1'b0;
         overflow_q   <= 1'b0;
         frame_done_q <= 1'b0;
         phase_q      <= PH_0;
         res_q        <= {PIXEL_W{1'b0}};
      end else begin
         vs_d_q       <= vs_d_d;
         vs_arm_q     <= vs_arm_d;
         frame_en_q   <= frame_en_d;
         sof_pend_q   <= sof_pend_d;
         overflow_q   <= overflow_d;
         frame_done_q <= frame_done_d;
         phase_q      <= phase_d;
         res_q        <= res_d;
      end
   end

   vp_sync_fifo #(
      .WIDTH (FIFO_W),
      .DEPTH (FIFO_DEPTH),
      .AW    (FIFO_AW)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_s),
      .push_data ({sof_pend_q, push_word_s}),
      .pop       (pop_s),
      .head_data (head_entry_s),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s)
   );

endmodule

// File: doc/vp_word_packer.md
# vp_word_packer

Video-path stage that sits directly after the cropping stage: it takes the cropped 24-bit pixel stream (gapped `pre_de`) and packs it densely into 32-bit words, with no padding between pixels, for the DMA/frame-buffer writer. Every 4 pixels become 3 words. A partial word at frame end is zero-padded and flushed. The block buffers words in a small FIFO behind a valid/ready master interface and reports frame completion and overflow.

## Interface
- `FIFO_DEPTH`, 16: word FIFO entries; must be a power of 2, at least 4.
- `FIFO_AW`, 4: log2(FIFO_DEPTH).
- `clk` in 1: video pixel clock; the only clock.
- `rst` in 1: reset, synchronous, active-high.
- `EN` in 1: packing enable; sampled only at frame start.
- `pre_vs` in 1: frame-valid from the cropping stage, active-high.
- `pre_de` in 1: pixel valid.
- `pre_data` in 24: pixel {R,G,B}.
- `m_valid` out 1: FIFO head word available.
- `m_ready` in 1: sink accepts the head word.
- `m_data` out 32: packed word.
- `m_sof` out 1: head word is the first word of its frame.
- `overflow` out 1: sticky; a word was dropped because the FIFO was full.
- `frame_done` out 1: one-cycle pulse when an enabled frame has been fully written into the FIFO.

## Operation
- `vs_d` holds `pre_vs` registered.
  - Rising edge (`pre_vs & ~vs_d`): `frame_en <= EN`. If EN=1: clear `overflow`, set `sof_pend`, force `phase` to 0.
  - Falling edge (`~pre_vs & vs_d`) with `frame_en` set: flush.
- A pixel is accepted when `frame_en & pre_vs & pre_de`. Otherwise `pre_de` is ignored, including while `pre_vs` is low.
- `phase` is a 2-bit counter 0→1→2→3→0; `res` is a 24-bit residue register. Little-endian packing, with p the accepted pixel:
  - phase 0: `res <= p`; no write.
  - phase 1: write `{p[7:0], res[23:0]}`; `res[15:0] <= p[23:8]`.
  - phase 2: write `{p[15:0], res[15:0]}`; `res[7:0] <= p[23:16]`.
  - phase 3: write `{p[23:0], res[7:0]}`.
- Flush (falling edge cycle):
  - phase 1: write `{8'h0, res[23:0]}`.
  - phase 2: write `{16'h0, res[15:0]}`.
  - phase 3: write `{24'h0, res[7:0]}`.
  - phase 0: no write.
  - In all cases, `phase <= 0` and `frame_done` pulses in the next cycle.
- Each write pushes `{sof_pend, word}`; `sof_pend` clears on the first successful push.
- Full FIFO:
  - A push while full is dropped and sets `overflow`, unless a pop occurs in the same cycle, in which case the push is accepted.
  - A dropped first word leaves `sof_pend` set, so `m_sof` still marks the first word actually stored for the frame.
  - Packing state advances regardless of drops.
- Pop when `m_valid & m_ready`.
- A frame started with EN=0 produces no words, no `frame_done`, and leaves `overflow` untouched.

## Timing
- Reset: `m_valid`=0, `m_data`=0, `m_sof`=0, `overflow`=0, `frame_done`=0; FIFO empty, `phase`=0, `vs_d`=0, `frame_en`=0, `sof_pend`=0.
- Reset mid-frame discards the partial word and the FIFO contents. With `pre_vs` still high after reset there is no rising edge, so nothing is packed until the next frame.
- Latency: a word completed by the pixel sampled at edge N shows `m_valid`=1 after edge N (show-ahead FIFO, head read combinationally).
- Sustained input is at most 3 words per 4 cycles. With `m_ready`=1 the FIFO never fills.
- `m_data` and `m_sof` are stable while `m_valid & ~m_ready`.
- Pixel and flush never coincide, because acceptance requires `pre_vs`=1.

## Structure
- Shared `vp_pkg` holds `PIXEL_W`=24, `WORD_W`=32 and the phase encoding constants.
- Sub-module `vp_sync_fifo`: width 33, depth `FIFO_DEPTH`, show-ahead, with full/empty and simultaneous push/pop support. The packer FSM stays in the top level.

## Test plan
- Packing: EN=1, one frame of pixels 0x112233, 0x445566, 0x778899, 0xAABBCC, `m_ready`=1 → words 0x66112233 (`m_sof`=1), 0x88994455, 0xAABBCC77; then `frame_done` pulses once.
- Flush: the same 4 pixels plus 0xDDEEFF, 0x010203, then `pre_vs` falls → words 4 and 5 are 0x03DDEEFF and 0x00000102; no further word.
- Backpressure: `FIFO_DEPTH`=16, `m_ready`=0, 24 pixels → `m_valid`=1 with exactly 16 words held and `overflow`=1. Draining yields the first 16 words in order, with `m_data` stable while stalled.
- Overflow clearing: next frame with EN=1 → `overflow` returns to 0 at the `pre_vs` rise. Simultaneous push/pop at full → no drop.
- EN gating: frame with EN=0 → no `m_valid`, no `frame_done`. EN toggling to 1 mid-frame → still nothing until the next frame.
- Reset mid-frame: assert `rst` after 2 pixels with `pre_vs` held high → all outputs 0. Pixels until the next `pre_vs` rise are ignored, and the next frame packs from phase 0.
